fetch: RTL
==========

FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000; word-aligned address of the first fetch after reset.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_b  input  1  reset; asynchronous assert, active-low.
REQ-004 ic_rd_addr  output  32  word address presented to the instruction cache.
REQ-005 ic_rd_req  output  1  fetch request to the instruction cache.
REQ-006 ic_rd_wait  input  1  cache miss in progress; data not valid this cycle.
REQ-007 ic_rd_data  input  32  instruction word; valid when ic_rd_req && !ic_rd_wait.
REQ-008 stall  input  1  decode cannot accept the head entry this cycle.
REQ-009 jmp  input  1  redirect request (branch or exception).
REQ-010 jmp_pc  input  32  redirect target.
REQ-011 bubble  output  1  no valid instruction presented to decode.
REQ-012 insn  output  32  instruction at queue head.
REQ-013 insn_pc  output  32  address of insn.

Function
REQ-014 The block SHALL hold a fetch PC register and a 2-entry FIFO of {insn, pc}; FIFO occupancy (0/1/2) is the only control state.
REQ-015 ic_rd_addr SHALL equal the fetch PC with bits [1:0] = 2'b00, combinationally.
REQ-016 ic_rd_req SHALL be 1 when jmp = 0 and (occupancy < 2, or occupancy = 2 and a pop occurs this cycle); otherwise 0.
REQ-017 Accept: ic_rd_req && !ic_rd_wait at a clock edge SHALL push {ic_rd_data, PC} and advance PC by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-018 Pop: !bubble && !stall at a clock edge SHALL remove the head entry; push and pop in the same cycle leave occupancy unchanged.
REQ-019 bubble SHALL be 1 iff occupancy = 0; insn/insn_pc SHALL reflect the head entry; when bubble = 1 their values are don't-care but stable.
REQ-020 Latency: on a cache hit, an instruction requested in cycle N SHALL appear at the head, with bubble = 0, in cycle N+1.
REQ-021 While ic_rd_wait = 1, PC and ic_rd_addr SHALL hold; no push occurs.
REQ-022 jmp = 1 at a clock edge SHALL flush the FIFO (occupancy 0), load PC with {jmp_pc[31:2], 2'b00}, and discard any concurrent accept or pop; bubble = 1 the following cycle.
REQ-023 jmp SHALL take priority over stall, accept, and pop in the same cycle.
REQ-024 Full FIFO with stall = 1: ic_rd_req = 0; PC and contents hold indefinitely.
REQ-025 Consecutive jmp cycles SHALL each reload PC; only the last target is fetched.

Reset
REQ-026 rst_b = 0 SHALL immediately clear occupancy to 0 and set PC to RESET_PC, including mid-miss or mid-flush.
REQ-027 During reset, outputs SHALL be ic_rd_req = 0, bubble = 1, and ic_rd_addr = RESET_PC.
REQ-028 The first request SHALL be issued in the first cycle after rst_b deasserts.

Structure
REQ-029 The shared package SHALL hold the instruction and address width constants (32) and the default RESET_PC.
REQ-030 The FIFO SHALL be a sub-module, fetch_queue: 2 entries, 64 bits wide, with push, pop, flush, full, and empty.

Verification
REQ-031 Reset with RESET_PC = 0, cache always hit, stall = 0 -> insn_pc = 0, 4, 8, ... on consecutive cycles; bubble = 0 from cycle 2 onward.
REQ-032 ic_rd_wait held high for 5 cycles at PC 0x40 -> ic_rd_addr = 0x40 throughout; bubble = 1 once the queue drains; 0x40 is delivered the cycle after wait drops.
REQ-033 stall held high for 4 cycles -> queue fills to 2, ic_rd_req = 0; on release, entries are delivered in order with no loss or duplication.
REQ-034 jmp = 1 with jmp_pc = 0x1003 while the queue is full and a hit is in flight -> next cycle bubble = 1 and ic_rd_addr = 0x1000; the next delivered insn_pc = 0x1000.
REQ-035 PC = 0xFFFF_FFFC with hits -> insn_pc sequence 0xFFFF_FFFC, 0x0000_0000.
REQ-036 rst_b asserted asynchronously mid-miss with occupancy 1 -> bubble = 1 and ic_rd_req = 0 immediately; after release, ic_rd_addr = RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, defaults and types for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [XLEN-1:0] DefaultResetPc = 32'h0000_0000;

  typedef struct packed {
    logic [ILEN-1:0] insn;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Cache-read and decode-side signals of the fetch unit, bundled with directional views.
interface fetch_if;
  import fetch_pkg::*;

  logic [XLEN-1:0] ic_rd_addr;
  logic            ic_rd_req;
  logic            ic_rd_wait;
  logic [ILEN-1:0] ic_rd_data;
  logic            stall;
  logic            jmp;
  logic [XLEN-1:0] jmp_pc;
  logic            bubble;
  logic [ILEN-1:0] insn;
  logic [XLEN-1:0] insn_pc;

  modport master (
    output ic_rd_addr, ic_rd_req, bubble, insn, insn_pc,
    input  ic_rd_wait, ic_rd_data, stall, jmp, jmp_pc
  );

  modport slave (
    input  ic_rd_addr, ic_rd_req, bubble, insn, insn_pc,
    output ic_rd_wait, ic_rd_data, stall, jmp, jmp_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Two-entry shifting FIFO of {insn, pc}; head is always entry 0, flush wins over push/pop.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_b,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty
);

  fetch_entry_t r_entry [2];
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign o_empty = (r_count == 2'd0);
  assign o_full  = (r_count == 2'd2);
  assign o_head  = r_entry[0];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_count    <= 2'd0;
      r_entry[0] <= '0;
      r_entry[1] <= '0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          r_entry[r_count[0]] <= i_data;
          r_count             <= r_count + 2'd1;
        end
        2'b01: begin
          r_entry[0] <= r_entry[1];
          r_count    <= r_count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new entry lands behind whatever survives the pop.
          if (r_count == 2'd1) begin
            r_entry[0] <= i_data;
          end else begin
            r_entry[0] <= r_entry[1];
            r_entry[1] <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch: PC register feeding the I-cache, with a 2-deep queue towards decode.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DefaultResetPc
) (
  input logic      clk,
  input logic      rst_b,
  fetch_if.master  bus
);

  logic [XLEN-1:0] r_pc;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_accept;

  assign w_pop    = !w_empty && !bus.stall;
  // Gated by rst_b so the request is low for the whole reset, not just after the first edge.
  assign bus.ic_rd_req  = rst_b && !bus.jmp && (!w_full || w_pop);
  assign w_accept       = bus.ic_rd_req && !bus.ic_rd_wait;
  assign bus.ic_rd_addr = word_align(r_pc);

  assign w_push_data.insn = bus.ic_rd_data;
  assign w_push_data.pc   = word_align(r_pc);

  assign bus.bubble  = w_empty;
  assign bus.insn    = w_head.insn;
  assign bus.insn_pc = w_head.pc;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_pc <= RESET_PC;
    end else if (bus.jmp) begin
      r_pc <= word_align(bus.jmp_pc);
    end else if (w_accept) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  fetch_queue u_queue (
    .clk     (clk),
    .rst_b   (rst_b),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_flush (bus.jmp),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule
